// File: rtl/bank_stream_reader.sv
// rtl/bank_stream_reader.sv - sequential bank read engine feeding a valid/ready stream
//
// Reads len consecutive words from the coefficient bank starting at base_addr
// (addresses wrap at the bank depth) and presents them as a valid/ready stream.
// The bank read port has one cycle of latency; a 2-entry FIFO absorbs consumer
// backpressure.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                begin a transfer (only honoured while idle)
//   base_addr, len       first address and word count, latched on an accepted start
//   busy, done           transfer in progress / 1-cycle completion pulse
//   bank_en, bank_ren    bank enable and read enable (identical)
//   bank_a2              bank read address
//   bank_q               bank read data, valid the cycle after bank_ren
//   out_data, out_valid  stream head word and FIFO non-empty
//   out_last             head word is the final word of the transfer
//   out_ready            consumer accepts when out_valid && out_ready

module bank_stream_reader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 256,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              bank_en,
   output logic              bank_ren,
   output logic [ADDR_W-1:0] bank_a2,
   input  logic [DATA_W-1:0] bank_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W:0]   len_r;
   logic [ADDR_W:0]   issued;
   logic [ADDR_W:0]   accepted;
   logic              rd_pend;

   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;

   logic              push;
   logic              pop;
   logic [2:0]        credit;

   assign pop  = out_valid && out_ready;
   assign push = rd_pend;

   // Occupancy after this edge, before counting a read issued this cycle.
   // A new read is allowed only if it still fits in the 2-entry FIFO.
   assign credit = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};

   assign bank_ren = (state == RUN) && (issued < len_r) && (credit < 3'd2);
   assign bank_en  = bank_ren;
   assign bank_a2  = base_r + issued[ADDR_W-1:0];

   assign busy      = (state != IDLE);
   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = fifo_mem[rd_ptr];
   // Words leave in order, so the accept count is the head word's index.
   assign out_last  = out_valid && (accepted == len_r - ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done        <= 1'b0;
         base_r      <= '0;
         len_r       <= '0;
         issued      <= '0;
         accepted    <= '0;
         rd_pend     <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= '0;
      end else begin
         done    <= 1'b0;
         rd_pend <= bank_ren;

         // The bank holds Q while idle, so only capture on the cycle after a read.
         if (push) begin
            fifo_mem[wr_ptr] <= bank_q;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            accepted <= accepted + ONE;
         end
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

         if (bank_ren) begin
            issued <= issued + ONE;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     base_r   <= base_addr;
                     len_r    <= (len > MAX_LEN) ? MAX_LEN : len;
                     issued   <= '0;
                     accepted <= '0;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               if (bank_ren && (issued == len_r - ONE)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Finish as soon as the last word is being accepted, so done
               // lands on the cycle right after the final handshake.
               if (!rd_pend && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
